// File: rtl/mult8_shared_sequencer.sv
// mult8_shared_sequencer: two-port round-robin scheduler computing 8x8
// unsigned products by running one 4x4 array multiplier over four steps.

// 4x4 unsigned combinational array multiplier (shift-and-add of partial products).
module mult8_core4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  // Sum the partial products a << j for every set bit j of b.
  always_comb begin
    p_o = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (b_i[j]) begin
        p_o = p_o + ({4'b0000, a_i} << j);
      end
    end
  end

endmodule

module mult8_shared_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [7:0]  req_a_0,
  input  logic [7:0]  req_b_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [7:0]  req_a_1,
  input  logic [7:0]  req_b_1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_product,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        id_q, id_d;
  logic        last_id_q, last_id_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic        busy_q, busy_d;

  logic        any_valid;
  logic        grant;
  logic        idle;
  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic [7:0]  core_p;
  logic [15:0] addend;

  // Arbitration: a lone requester wins; on contention the port that did not win last time wins.
  always_comb begin
    any_valid   = req_valid_0 | req_valid_1;
    grant       = (req_valid_0 && req_valid_1) ? ~last_id_q : req_valid_1;
    idle        = (state_q == S_IDLE);
    req_ready_0 = idle && !rst && any_valid && (grant == 1'b0);
    req_ready_1 = idle && !rst && any_valid && (grant == 1'b1);
  end

  // Nibble selection for the shared core, driven from the latched operands.
  always_comb begin
    core_a = step_q[1] ? a_q[7:4] : a_q[3:0];
    core_b = step_q[0] ? b_q[7:4] : b_q[3:0];
  end

  mult8_core4x4 u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (core_p)
  );

  // Align the partial product to its weight for the current step.
  always_comb begin
    case (step_q)
      2'd0:       addend = {8'h00, core_p};
      2'd1, 2'd2: addend = {4'h0, core_p, 4'h0};
      default:    addend = {core_p, 8'h00};
    endcase
  end

  // Next-state and datapath update for the IDLE -> MUL -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    acc_d     = acc_q;
    step_d    = step_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          a_d       = grant ? req_a_1 : req_a_0;
          b_d       = grant ? req_b_1 : req_b_0;
          id_d      = grant;
          last_id_d = grant;
          acc_d     = '0;
          step_d    = '0;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        acc_d  = acc_q + addend;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      acc_q     <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
    end
  end

  assign resp_valid   = (state_q == S_DONE);
  assign resp_product = acc_q;
  assign resp_id      = id_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mult8_shared_sequencer.sv
// Directed and randomized self-checking bench for mult8_shared_sequencer.
module tb_mult8_shared_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_ready_0;
  logic [7:0]  req_a_0, req_b_0;
  logic        req_valid_1, req_ready_1;
  logic [7:0]  req_a_1, req_b_1;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_product;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult8_shared_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hold reset for two edges with both requesters valid; readies must stay low.
  task automatic do_reset();
    rst = 1'b1;
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("rst_ready0", req_ready_0, 0);
    check("rst_ready1", req_ready_1, 0);
    @(posedge clk); #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", resp_product, 0);
    check("rst_id", resp_id, 0);
    rst = 1'b0;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
  endtask

  // Present one request on port p until accepted; returns just after the accepting edge.
  task automatic send(input int p, input logic [7:0] a, input logic [7:0] b);
    int n;
    logic rdy;
    n = 0;
    if (p == 0) begin req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; end
    else        begin req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; end
    forever begin
      @(negedge clk);
      rdy = (p == 0) ? req_ready_0 : req_ready_1;
      if (rdy) break;
      n++;
      if (n > 20) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
  endtask

  // Called just after the accepting edge with resp_ready high: checks latency and result.
  task automatic expect_resp(input string tag, input logic id, input logic [15:0] prod);
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) break;
      check({tag, "_busy"}, busy, 1);
      cnt++;
      if (cnt > 20) break;
    end
    check({tag, "_lat"}, cnt, 4);
    check({tag, "_id"}, resp_id, id);
    check({tag, "_prod"}, resp_product, prod);
    check({tag, "_busy_done"}, busy, 1);
    @(posedge clk); #1;
  endtask

  logic [7:0]  ta [4] = '{8'h00, 8'h01, 8'h10, 8'hF0};
  logic [7:0]  tb [4] = '{8'h37, 8'hFF, 8'h10, 8'h0F};
  logic [15:0] tp [4] = '{16'h0000, 16'h00FF, 16'h0100, 16'h0E10};
  logic        t2_id [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] t2_pr [3] = '{16'h03A8, 16'h0100, 16'h03A8};

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          acc0, acc1, cyc, n, seen;
  logic        f0, f1, fr, last_acc;
  logic [15:0] expv;

  initial begin
    req_a_0 = '0; req_b_0 = '0; req_a_1 = '0; req_b_1 = '0;

    // Single max-value request on port 0.
    do_reset();
    resp_ready = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 8'hFF; req_b_0 = 8'hFF;
    @(negedge clk);
    check("t1_ready0", req_ready_0, 1);
    check("t1_ready1", req_ready_1, 0);
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    expect_resp("t1", 1'b0, 16'hFE01);
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_valid_after", resp_valid, 0);
    @(posedge clk); #1;

    // Both ports continuously valid: responses alternate starting at port 0.
    do_reset();
    resp_ready = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 8'h12; req_b_0 = 8'h34;
    req_valid_1 = 1'b1; req_a_1 = 8'h80; req_b_1 = 8'h02;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      check("t2_onehot", req_ready_0 & req_ready_1, 0);
      if (resp_valid && resp_ready) begin
        check("t2_id", resp_id, t2_id[n]);
        check("t2_prod", resp_product, t2_pr[n]);
        n++;
        if (n == 3) break;
      end
    end
    check("t2_count", n, 3);
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;

    // Back-pressure in DONE with both requesters waiting.
    do_reset();
    resp_ready = 1'b0;
    req_valid_0 = 1'b1; req_a_0 = 8'h12; req_b_0 = 8'h34;
    req_valid_1 = 1'b1; req_a_1 = 8'h80; req_b_1 = 8'h02;
    n = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) break;
      n++;
      if (n > 20) break;
    end
    check("t3_reach_done", n <= 20, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t3_valid", resp_valid, 1);
      check("t3_prod", resp_product, 16'h03A8);
      check("t3_id", resp_id, 0);
      check("t3_ready0", req_ready_0, 0);
      check("t3_ready1", req_ready_1, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_hs", resp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_rr_ready0", req_ready_0, 0);
    check("t3_rr_ready1", req_ready_1, 1);
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    expect_resp("t3b", 1'b1, 16'h0100);

    // Reset pulse during MUL step 2 discards the operation.
    do_reset();
    resp_ready = 1'b1;
    send(0, 8'h55, 8'hAA);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_valid", resp_valid, 0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("t4_no_resp", seen, 0);
    @(posedge clk); #1;
    req_valid_0 = 1'b1; req_a_0 = 8'h0F; req_b_0 = 8'h0F;
    req_valid_1 = 1'b1; req_a_1 = 8'h33; req_b_1 = 8'h33;
    @(negedge clk);
    check("t4_ready0", req_ready_0, 1);
    check("t4_ready1", req_ready_1, 0);
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    expect_resp("t4b", 1'b0, 16'h00E1);

    // Edge operands, alternating ports.
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(i % 2, ta[i], tb[i]);
      expect_resp("t5", 1'(i % 2), tp[i]);
    end

    // Random traffic with a per-port in-order scoreboard.
    do_reset();
    acc0 = 0; acc1 = 0; cyc = 0; last_acc = 1'b1;
    req_a_0 = 8'($urandom); req_b_0 = 8'($urandom);
    req_a_1 = 8'($urandom); req_b_1 = 8'($urandom);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1; resp_ready = 1'b1;
    while (((acc0 + acc1) < 2000 || q0.size() + q1.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      f0 = req_valid_0 && req_ready_0;
      f1 = req_valid_1 && req_ready_1;
      fr = resp_valid && resp_ready;
      check("rnd_onehot", req_ready_0 & req_ready_1, 0);
      if ((f0 || f1) && req_valid_0 && req_valid_1)
        check("rnd_rr", f1, (last_acc == 1'b0) ? 1 : 0);
      if (f0 || f1) last_acc = f1;
      if (f0) begin q0.push_back({8'h00, req_a_0} * {8'h00, req_b_0}); acc0++; end
      if (f1) begin q1.push_back({8'h00, req_a_1} * {8'h00, req_b_1}); acc1++; end
      if (fr) begin
        if (resp_id == 1'b0) begin
          if (q0.size() == 0) check("rnd_dup0", 1, 0);
          else begin expv = q0.pop_front(); check("rnd_prod0", resp_product, expv); end
        end else begin
          if (q1.size() == 0) check("rnd_dup1", 1, 0);
          else begin expv = q1.pop_front(); check("rnd_prod1", resp_product, expv); end
        end
      end
      @(posedge clk); #1;
      if (f0) begin req_a_0 = 8'($urandom); req_b_0 = 8'($urandom); end
      if (f1) begin req_a_1 = 8'($urandom); req_b_1 = 8'($urandom); end
      req_valid_0 = (acc0 < 1000) && ($urandom_range(0, 3) != 0);
      req_valid_1 = (acc1 < 1000) && ($urandom_range(0, 3) != 0);
      resp_ready  = ($urandom_range(0, 2) != 0);
    end
    check("rnd_budget", cyc < 40000, 1);
    check("rnd_acc0", acc0, 1000);
    check("rnd_acc1", acc1, 1000);
    check("rnd_lost0", q0.size(), 0);
    check("rnd_lost1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult8_shared_sequencer.md
# mult8_shared_sequencer

Two-port scheduler that computes 8x8 unsigned products by time-sharing one 4x4 combinational array multiplier core over four cycles. Round-robin arbitration lets two requesters share that core. A single response channel returns each product tagged with the requester ID. The block sits between requesters such as DSP or address-generation clients and the one 4x4 core instance it owns internally.

## Interface

Parameters:
- none. Port count is fixed at 2 and operand width is fixed at 8.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_0  in  1  port 0 has an operand pair
- req_ready_0  out  1  port 0 request accepted this cycle
- req_a_0  in  8  port 0 multiplicand
- req_b_0  in  8  port 0 multiplier
- req_valid_1  in  1  port 1 has an operand pair
- req_ready_1  out  1  port 1 request accepted this cycle
- req_a_1  in  8  port 1 multiplicand
- req_b_1  in  8  port 1 multiplier
- resp_valid  out  1  product available
- resp_ready  in  1  consumer takes product
- resp_id  out  1  index of the port that issued the product
- resp_product  out  16  unsigned a*b
- busy  out  1  high whenever the state is not IDLE

## Operation

- The FSM has three states:
  - IDLE: no operation in flight.
  - MUL: runs steps 0..3 of one multiplication.
  - DONE: the product is held until the consumer takes it.
- Arbitration happens only in IDLE. It is combinational from req_valid_*.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port not equal to last_id is granted.
  - last_id resets to 1, so port 0 wins the first contest.
- req_ready_i = (state==IDLE) && granted==i. At most one ready is high in any cycle. Both readies are 0 outside IDLE.
- Acceptance is req_valid_i && req_ready_i at a rising edge. On acceptance:
  - latch a, b and id;
  - set last_id = i;
  - clear the accumulator to 0;
  - set step = 0;
  - move to MUL.
- Requesters hold valid and operands stable until accepted. Dropping valid before acceptance is legal and withdraws the request.
- Each MUL step feeds one nibble pair to the core and adds the core's 8-bit result, shifted, into a 16-bit accumulator:
  - step 0: aL*bL, shift 0
  - step 1: aL*bH, shift 4
  - step 2: aH*bL, shift 4
  - step 3: aH*bH, shift 8
- After step 3 the FSM moves to DONE, and resp_product and resp_id are driven from registers.
- Arithmetic: all values are unsigned. The 16-bit accumulator cannot overflow; the maximum result is 0xFF*0xFF = 0xFE01.
- Leaving DONE:
  - resp_valid && resp_ready at an edge moves the FSM to IDLE.
  - With resp_ready low, DONE holds indefinitely.
  - While in DONE, resp_product and resp_id are stable and no new request is accepted.
- The core's inputs are driven from registers, so no combinational path runs from req_* to the core.

## Timing

- Reset values: state=IDLE, resp_valid=0, resp_product=0, resp_id=0, busy=0, last_id=1.
- While rst is high, req_ready_0/1 are both 0.
- Latency:
  - The request is accepted at edge E0.
  - The MUL steps update at edges E1..E4.
  - resp_valid goes high in the cycle after E4, i.e. 4 cycles after acceptance.
- Throughput:
  - The response handshake at edge E5 returns the FSM to IDLE.
  - The earliest next acceptance is edge E6.
  - Maximum throughput is one product per 6 cycles with resp_ready held high.
- resp_valid may depend only on registers. resp_ready has no combinational path to any output except through the state change at the next edge.
- Reset mid-operation (rst high at any edge while in MUL or DONE):
  - the FSM returns to IDLE at that edge;
  - the in-flight result is discarded and no response is ever issued for it;
  - last_id returns to 1.
- Simultaneous events:
  - A request arriving in DONE is stalled, not dropped.
  - A request that becomes valid in the same cycle as the response handshake is seen in the following IDLE cycle.
- busy is registered and equals (state != IDLE).

## Test plan

- Port 0 sends a=0xFF, b=0xFF; resp_ready is held at 1. Required:
  - req_ready_0=1 in that cycle;
  - resp_valid high exactly 4 cycles after acceptance with resp_product=0xFE01 and resp_id=0;
  - busy high from the edge after acceptance until the response handshake.
- Both ports are valid continuously; port 0 sends 0x12*0x34 and port 1 sends 0x80*0x02. Required:
  - responses alternate, starting with id 0 product 0x03A8, then id 1 product 0x0100, then id 0 again;
  - there are never two readies in one cycle.
- Back-pressure: resp_ready is held 0 for 10 cycles while in DONE with both req_valids high. Required:
  - resp_valid, resp_product and resp_id are stable throughout;
  - req_ready_0/1 are 0 throughout;
  - after resp_ready rises, the handshake completes and the next grant follows round-robin.
- Reset mid-operation: rst is pulsed for 1 cycle during MUL step 2 of 0x55*0xAA. Required:
  - IDLE at the next edge with resp_valid=0;
  - no response for the aborted op;
  - the next request 0x0F*0x0F returns 0x00E1 with id 0.
- Edge operands: the bench sends 0x00*0x37, 0x01*0xFF, 0x10*0x10 and 0xF0*0x0F. Required products are 0x0000, 0x00FF, 0x0100 and 0x0E10.
- Random: 2000 requests with random valid/ready toggling on both ports. The scoreboard checks per-port order, the exact a*b value, and that no request is lost or duplicated.
